// File: rtl/ingress_fifo.sv
// Per-slave-port ingress FIFO for the AXI-Stream crossbar: buffers {data, dest, last} beats
// and presents the head beat. Optional macro INGRESS_DEST_LOCK_EN locks dest per packet.
module ingress_fifo #(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned M_DATA_COUNT = 3,
  parameter int unsigned DEPTH        = 4,
  localparam int unsigned T_DEST_WIDTH = $clog2(M_DATA_COUNT),
  localparam int unsigned CNT_WIDTH    = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_DEST_WIDTH-1:0] s_dest_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] q_data_o,
  output logic [T_DEST_WIDTH-1:0] q_dest_o,
  output logic                    q_last_o,
  output logic                    q_valid_o,
  input  logic                    pop_i,
  output logic [CNT_WIDTH-1:0]    count_o,
  output logic                    drop_o
);

  localparam int unsigned PtrWidth = $clog2(DEPTH);
  // Only a non-power-of-two master count leaves dest codes that name no master.
  localparam bit DestCheck = (M_DATA_COUNT != (1 << T_DEST_WIDTH));
  localparam logic [CNT_WIDTH-1:0] FullCnt = CNT_WIDTH'(DEPTH);
  localparam logic [T_DEST_WIDTH:0] DestLimit = (T_DEST_WIDTH + 1)'(M_DATA_COUNT);

  logic [T_DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [T_DEST_WIDTH-1:0] mem_dest [DEPTH];
  logic                    mem_last [DEPTH];

  logic [PtrWidth-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    drop_q, drop_d;
  logic                    push, pop, dest_bad, bad, store;
  logic [T_DEST_WIDTH-1:0] wr_dest;

`ifdef INGRESS_DEST_LOCK_EN
  logic                    in_pkt_q, in_pkt_d;
  logic                    drop_pkt_q, drop_pkt_d;
  logic [T_DEST_WIDTH-1:0] lock_dest_q, lock_dest_d;
`endif

  assign s_ready_o = (cnt_q != FullCnt);
  assign q_valid_o = (cnt_q != '0);
  assign count_o   = cnt_q;
  assign drop_o    = drop_q;
  assign q_data_o  = mem_data[rptr_q];
  assign q_dest_o  = mem_dest[rptr_q];
  assign q_last_o  = mem_last[rptr_q];

  always_comb begin
    push     = s_valid_i && s_ready_o;
    pop      = pop_i && q_valid_o;
    dest_bad = DestCheck && ({1'b0, s_dest_i} >= DestLimit);
`ifdef INGRESS_DEST_LOCK_EN
    // Dest and drop decision come from the first beat; later beats inherit them.
    wr_dest     = in_pkt_q ? lock_dest_q : s_dest_i;
    bad         = in_pkt_q ? drop_pkt_q : dest_bad;
    in_pkt_d    = in_pkt_q;
    lock_dest_d = lock_dest_q;
    drop_pkt_d  = drop_pkt_q;
    if (push) begin
      in_pkt_d = !s_last_i;
      if (!in_pkt_q) begin
        lock_dest_d = s_dest_i;
        drop_pkt_d  = dest_bad;
      end
    end
`else
    wr_dest = s_dest_i;
    bad     = dest_bad;
`endif
    store  = push && !bad;
    drop_d = push && bad;
    wptr_d = store ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    unique case ({store, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
`ifdef INGRESS_DEST_LOCK_EN
      in_pkt_q    <= 1'b0;
      drop_pkt_q  <= 1'b0;
      lock_dest_q <= '0;
`endif
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
`ifdef INGRESS_DEST_LOCK_EN
      in_pkt_q    <= in_pkt_d;
      drop_pkt_q  <= drop_pkt_d;
      lock_dest_q <= lock_dest_d;
`endif
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_data[wptr_q] <= s_data_i;
      mem_dest[wptr_q] <= wr_dest;
      mem_last[wptr_q] <= s_last_i;
    end
  end

endmodule

// File: tb/tb_ingress_fifo.sv
// Self-checking bench for ingress_fifo: queue-based reference model compared every cycle,
// plus directed literal checks on the scenarios that pin the model.
module tb_ingress_fifo;

  localparam int unsigned M     = 3;
  localparam int unsigned DEPTH = 4;
`ifdef INGRESS_DEST_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] dest;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = '0;
  logic [1:0] s_dest = '0;
  logic       s_last = 1'b0;
  logic       s_valid = 1'b0;
  logic       pop = 1'b0;
  logic       s_ready, q_last, q_valid, drop;
  logic [7:0] q_data;
  logic [1:0] q_dest;
  logic [2:0] count;

  int    n_chk = 0;
  int    n_fail = 0;
  bit    chk_en = 1'b0;
  beat_t mq[$];
  bit    m_drop = 1'b0;
  bit    m_inpkt = 1'b0;
  bit    m_dpkt = 1'b0;
  logic [1:0] m_lock = '0;
  logic [1:0] raw_dest [3] = '{2'd2, 2'd0, 2'd1};

  ingress_fifo #(
    .T_DATA_WIDTH(8),
    .M_DATA_COUNT(M),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_data_i(s_data),
    .s_dest_i(s_dest),
    .s_last_i(s_last),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .q_data_o(q_data),
    .q_dest_o(q_dest),
    .q_last_o(q_last),
    .q_valid_o(q_valid),
    .pop_i(pop),
    .count_o(count),
    .drop_o(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated from the inputs applied at this edge.
  task automatic model_step();
    bit acc, popv, oor, bad;
    logic [1:0] wd;
    beat_t b;
    if (!rst_n) begin
      mq.delete();
      m_drop = 1'b0;
      m_inpkt = 1'b0;
      m_dpkt = 1'b0;
      m_lock = '0;
    end else begin
      acc  = s_valid && (mq.size() < DEPTH);
      popv = pop && (mq.size() > 0);
      oor  = (int'(s_dest) >= M);
      if (LockEn && m_inpkt) begin
        wd  = m_lock;
        bad = m_dpkt;
      end else begin
        wd  = s_dest;
        bad = oor;
      end
      if (LockEn && acc) begin
        if (!m_inpkt) begin
          m_lock = s_dest;
          m_dpkt = oor;
        end
        m_inpkt = !s_last;
      end
      if (popv) void'(mq.pop_front());
      if (acc && !bad) begin
        b.data = s_data;
        b.dest = wd;
        b.last = s_last;
        mq.push_back(b);
      end
      m_drop = acc && bad;
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic [1:0] de, input logic l,
                     input logic p);
    s_valid = v;
    s_data  = d;
    s_dest  = de;
    s_last  = l;
    pop     = p;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("q_valid", 32'(q_valid), 32'(mq.size() != 0));
      chk("s_ready", 32'(s_ready), 32'(mq.size() != DEPTH));
      chk("drop", 32'(drop), 32'(m_drop));
      if (mq.size() != 0) begin
        chk("head_data", 32'(q_data), 32'(mq[0].data));
        chk("head_dest", 32'(q_dest), 32'(mq[0].dest));
        chk("head_last", 32'(q_last), 32'(mq[0].last));
      end
    end
  end

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(q_valid), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);

    // Three beats, no pop.
    cyc(1'b1, 8'h11, 2'd1, 1'b0, 1'b0);
    chk("fill1_count", 32'(count), 32'd1);
    cyc(1'b1, 8'h22, 2'd1, 1'b0, 1'b0);
    chk("fill2_count", 32'(count), 32'd2);
    cyc(1'b1, 8'h33, 2'd1, 1'b1, 1'b0);
    chk("fill3_count", 32'(count), 32'd3);
    chk("fill3_head", 32'(q_data), 32'h11);
    chk("fill3_valid", 32'(q_valid), 32'd1);

    // Fill to DEPTH, then a held fifth beat accepted only after a pop.
    cyc(1'b1, 8'h44, 2'd0, 1'b1, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(s_ready), 32'd0);
    cyc(1'b1, 8'h55, 2'd2, 1'b0, 1'b0);
    chk("held_count", 32'(count), 32'd4);
    cyc(1'b1, 8'h55, 2'd2, 1'b0, 1'b1);
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_ready", 32'(s_ready), 32'd1);
    chk("fullpop_head", 32'(q_data), 32'h22);
    cyc(1'b1, 8'h55, 2'd2, 1'b1, 1'b0);
    chk("fifth_count", 32'(count), 32'd4);

    // Drain, then pop while empty.
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    chk("drain_count", 32'(count), 32'd0);
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    chk("emptypop_count", 32'(count), 32'd0);
    chk("emptypop_valid", 32'(q_valid), 32'd0);

    // Concurrent push/pop across pointer wrap; occupancy holds at 2.
    cyc(1'b1, 8'h80, 2'd1, 1'b1, 1'b0);
    cyc(1'b1, 8'h81, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cyc(1'b1, 8'(8'h82 + i), 2'(i % 3), 1'b1, 1'b1);
      chk("stream_count", 32'(count), 32'd2);
      chk("stream_head", 32'(q_data), 32'(8'h81 + i));
    end
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    chk("stream_drained", 32'(count), 32'd0);

    // Out-of-range dest is handshaken and dropped.
    cyc(1'b1, 8'h77, 2'd3, 1'b1, 1'b0);
    chk("drop_pulse", 32'(drop), 32'd1);
    chk("drop_count", 32'(count), 32'd0);
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    chk("drop_clear", 32'(drop), 32'd0);

    // Packet with varying dest: locked to the first beat only when the lock is built in.
    cyc(1'b1, 8'hA1, 2'd2, 1'b0, 1'b0);
    cyc(1'b1, 8'hA2, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 8'hA3, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("pkt_dest", 32'(q_dest), LockEn ? 32'd2 : 32'(raw_dest[i]));
      cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    end

    // Reset with beats stored, mid-packet.
    cyc(1'b1, 8'hB1, 2'd1, 1'b0, 1'b0);
    cyc(1'b1, 8'hB2, 2'd1, 1'b0, 1'b0);
    cyc(1'b1, 8'hB3, 2'd1, 1'b0, 1'b0);
    do_reset();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_valid", 32'(q_valid), 32'd0);
    chk("midrst_ready", 32'(s_ready), 32'd1);
    cyc(1'b1, 8'h99, 2'd0, 1'b1, 1'b0);
    chk("postrst_head", 32'(q_data), 32'h99);
    chk("postrst_dest", 32'(q_dest), 32'd0);
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ingress_fifo.md
# ingress_fifo

Per-slave-port ingress buffer for the AXI-Stream crossbar. Sits between an external slave-side stream port and the per-master round-robin arbiters. It absorbs beats (data, dest, last) into a circular FIFO and presents the head beat as a valid/data/dest/last tuple. It pops the head when the crossbar signals that the arbiter owning this port has consumed it. One instance per slave port; its head outputs drive that port's entry in the arbiters' `s_data_i`/`s_dest_i`/`s_last_i`/`s_valid_i` arrays.

## Interface
Parameters:
- T_DATA_WIDTH, 8, beat data width
- M_DATA_COUNT, 3, number of master ports; sets dest width
- DEPTH, 4, FIFO entries; power of two, ≥2
- T_DEST_WIDTH (localparam), $clog2(M_DATA_COUNT), dest width
- CNT_WIDTH (localparam), $clog2(DEPTH)+1, occupancy width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- s_data_i  in  T_DATA_WIDTH  incoming beat data
- s_dest_i  in  T_DEST_WIDTH  incoming beat destination master
- s_last_i  in  1  incoming beat ends packet
- s_valid_i  in  1  incoming beat valid
- s_ready_o  out  1  FIFO can accept a beat
- q_data_o  out  T_DATA_WIDTH  head beat data
- q_dest_o  out  T_DEST_WIDTH  head beat destination
- q_last_o  out  1  head beat last flag
- q_valid_o  out  1  head entry valid (FIFO non-empty)
- pop_i  in  1  head beat consumed this cycle
- count_o  out  CNT_WIDTH  current occupancy
- drop_o  out  1  one-cycle pulse: beat with out-of-range dest discarded

## Operation
- Storage: DEPTH entries of {data, dest, last}; write pointer wptr and read pointer rptr, each $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy register cnt.
- Push: s_valid_i && s_ready_o. Writes the beat at wptr, then wptr+1.
- Pop: pop_i && q_valid_o. Advances rptr by 1. pop_i while empty is ignored: no pointer or count change.
- s_ready_o = (cnt != DEPTH), combinational from registered state. It does not look ahead at a same-cycle pop, so a full FIFO accepts nothing even while popping.
- Simultaneous push and pop, not full and not empty: both take effect and cnt is unchanged.
- Push into an empty FIFO: the beat becomes visible on q_* the next cycle, never the same cycle.
- Dest range check: a beat with s_dest_i ≥ M_DATA_COUNT is handshaken (ready honoured) but not stored, and drop_o pulses. This check applies only when M_DATA_COUNT is not a power of two; otherwise drop_o is tied 0.
- q_data_o/q_dest_o/q_last_o = entry at rptr, combinational read. When q_valid_o = 0 these outputs are don't-care.
- q_valid_o = (cnt != 0). count_o = cnt.
- Reset (rst_n = 0 at a clock edge): wptr, rptr, cnt = 0; q_valid_o = 0; s_ready_o = 1 from the following cycle; drop_o = 0; packet-tracking state cleared.
- Reset mid-packet discards all stored beats, including partial packets. Storage contents are not cleared.

## Timing
- Push-to-head latency: 1 cycle, valid at the edge after acceptance.
- Pop takes effect at the clock edge where pop_i = 1. The next entry appears on q_* after that edge.
- Throughput: 1 beat/cycle in and out concurrently when 0 < cnt < DEPTH.
- Full with pop_i = 1: s_ready_o rises the next cycle.
- No combinational path from pop_i or s_valid_i to any output.

## Configuration
- Macro: INGRESS_DEST_LOCK_EN.
- Defined:
  - dest is captured from the first beat of each packet (the first beat after reset or after a beat with last = 1).
  - That captured dest is stored for every beat of the packet; later s_dest_i values within the packet are ignored.
  - The range check applies to the first beat only. A dropped first beat drops the whole packet through its last beat, with drop_o pulsing on each dropped beat.
- Undefined: each beat stores its own s_dest_i, and the range check applies per beat.

## Test plan
- Reset, then push 3 beats (data 0x11/0x22/0x33, dest 1, last on the third), no pop → cycle after each push count_o = 1/2/3; q_data_o = 0x11, q_valid_o = 1.
- DEPTH = 4, push 5 beats back-to-back, no pop → s_ready_o falls after the 4th accept; the 5th is held and accepted the cycle after one pop; count_o returns to 4.
- Fill and drain 3 × DEPTH beats with concurrent push and pop every cycle → output order equals input order across pointer wrap-around; count_o stays constant.
- pop_i = 1 while empty → count_o stays 0, q_valid_o stays 0, no pointer change.
- M_DATA_COUNT = 3, push dest = 3 → drop_o pulses for 1 cycle, count_o unchanged. With INGRESS_DEST_LOCK_EN, a 3-beat packet whose beats carry dest 2/0/1 → all three beats are stored with dest = 2.
- rst_n low for 1 cycle with 3 beats stored → next cycle count_o = 0, q_valid_o = 0, s_ready_o = 1; the next pushed beat is the first one seen at the head.
